prog_loader: RTL

Upstream program loader for the 8-bit CPU. Receives a length-prefixed, checksummed byte frame over a valid/ready stream and writes it into the CPU's 256×8 RAM starting at a fixed base address. While loading, it holds the CPU stopped and owns the RAM address/data/write-enable bus. After a good checksum it releases the bus and pulses the stage controller's `run` input.

---
 rtl/prog_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program loader: takes a length-prefixed, checksummed byte frame and writes it into
// CPU RAM at START_ADDR, holding the CPU off the bus until the checksum byte arrives.
module prog_loader #(
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_wren,
  output logic       bus_own,
  output logic       cpu_halt,
  output logic       cpu_run,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [8:0] count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_SUM, S_RUN, S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] len_q, len_d;
  logic [8:0] count_q, count_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       wren_q, wren_d;
  logic       ready_q, ready_d;
  logic       own_q, own_d;
  logic       run_q, run_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       xfer;

  // ready_q is exactly "state is LEN/DATA/SUM", so it doubles as the transfer qualifier
  assign xfer = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          count_d = 9'd0;
          acc_d   = 8'd0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          len_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          acc_d   = acc_q + in_data;
          wren_d  = 1'b1;
          addr_d  = START_ADDR + count_q[7:0];
          data_d  = in_data;
          count_d = count_q + 9'd1;
          if (count_d == len_q) state_d = S_SUM;
        end
      end
      S_SUM: begin
        if (xfer) begin
          if (in_data == acc_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_SUM);
    own_d   = ready_d;
    run_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 9'd0;
      count_q <= 9'd0;
      acc_q   <= 8'd0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      wren_q  <= 1'b0;
      ready_q <= 1'b0;
      own_q   <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      ready_q <= ready_d;
      own_q   <= own_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = ready_q;
  assign busy     = ready_q;
  assign bus_own  = own_q;
  assign cpu_halt = own_q;
  assign cpu_run  = run_q;
  assign done     = done_q;
  assign err      = err_q;
  assign count    = count_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign mem_wren = wren_q;

endmodule
